// File: rtl/uart_mem_loader.sv
// Receives 8N1 bytes, packs four little-endian into a word and writes it to DataMemory at sequential addresses.
// The write strobe appears one cycle after the 4th stop-bit sample; there is no backpressure because memory always accepts.
module uart_mem_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0004,
    parameter logic [31:0] ADDR_STEP    = 32'h0000_0004,
    parameter int          MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        load_enable,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        frame_error
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]      LAST_WORD = 16'(MAX_WORDS - 1);

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_sync_q, rx_sync_d;
    logic               load_en_prev_q, load_en_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        word_q, word_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_address_q, mem_address_d;
    logic [31:0]        mem_write_data_q, mem_write_data_d;
    logic [15:0]        word_count_q, word_count_d;
    logic               done_q, done_d;
    logic               frame_error_q, frame_error_d;
    logic [31:0]        word_ins;

    always_comb begin
        word_ins = word_q;
        word_ins[{byte_idx_q, 3'b000} +: 8] = shift_q;
    end

    always_comb begin
        state_d          = state_q;
        rx_meta_d        = rx;
        rx_sync_d        = rx_meta_q;
        load_en_prev_d   = load_enable;
        cnt_d            = cnt_q;
        bit_idx_d        = bit_idx_q;
        shift_d          = shift_q;
        byte_idx_d       = byte_idx_q;
        word_d           = word_q;
        mem_write_d      = 1'b0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        word_count_d     = word_count_q;
        done_d           = done_q;
        frame_error_d    = frame_error_q;

        if (!load_enable) begin
            // Session paused: abandon any byte and partial word, keep session results.
            state_d    = IDLE;
            cnt_d      = '0;
            bit_idx_d  = '0;
            byte_idx_d = '0;
        end else if (!load_en_prev_q) begin
            state_d       = IDLE;
            cnt_d         = '0;
            bit_idx_d     = '0;
            byte_idx_d    = '0;
            word_count_d  = '0;
            done_d        = 1'b0;
            frame_error_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!done_q && !rx_sync_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rx_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (!rx_sync_q) begin
                            frame_error_d = 1'b1;
                        end else begin
                            word_d = word_ins;
                            if (byte_idx_q == 2'd3) begin
                                mem_write_d      = 1'b1;
                                mem_write_data_d = word_ins;
                                mem_address_d    = BASE_ADDR + ({16'd0, word_count_q} * ADDR_STEP);
                                word_count_d     = word_count_q + 16'd1;
                                done_d           = (word_count_q == LAST_WORD);
                                byte_idx_d       = '0;
                            end else begin
                                byte_idx_d = byte_idx_q + 2'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            rx_meta_q        <= 1'b1;
            rx_sync_q        <= 1'b1;
            load_en_prev_q   <= 1'b0;
            cnt_q            <= '0;
            bit_idx_q        <= '0;
            shift_q          <= '0;
            byte_idx_q       <= '0;
            word_q           <= '0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            word_count_q     <= '0;
            done_q           <= 1'b0;
            frame_error_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            rx_meta_q        <= rx_meta_d;
            rx_sync_q        <= rx_sync_d;
            load_en_prev_q   <= load_en_prev_d;
            cnt_q            <= cnt_d;
            bit_idx_q        <= bit_idx_d;
            shift_q          <= shift_d;
            byte_idx_q       <= byte_idx_d;
            word_q           <= word_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            word_count_q     <= word_count_d;
            done_q           <= done_d;
            frame_error_q    <= frame_error_d;
        end
    end

    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign word_count     = word_count_q;
    assign done           = done_q;
    assign frame_error    = frame_error_q;
    assign busy           = (state_q != IDLE) || (byte_idx_q != 2'd0);

endmodule
